// File: rtl/axis_lrelu_requant.sv
// -----------------------------------------------------------------------------
// axis_lrelu_requant
//
// Per-lane integer requantiser with optional leaky-ReLU for an AXI-Stream
// pipeline. Each beat carries CH signed accumulators. The first beat of every
// iteration is a config beat that sets, for each lane, a signed multiplier, an
// unsigned right shift and an activation select. The data beats that follow go
// through a three-stage pipeline:
//   S1: p = x * mul
//   S2: r = (p + rnd) >>> sh
//   S3: optional leaky slope (r >>> ALPHA_SHIFT for negative r), then saturate
//
// Compile-time option:
//   LRELU_ROUND_EN  defined   -> rnd = 2^(sh-1) for sh > 0 (round half up)
//                   undefined -> rnd = 0 (floor / truncation toward -inf)
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_tvalid/tready  slave handshake
//   s_axis_tdata         CH lanes of WORD_WIDTH_IN, lane i at [i*WORD_WIDTH_IN +:]
//   s_axis_tlast         last data beat of an iteration
//   m_axis_tvalid/tready  master handshake
//   m_axis_tdata         CH lanes of WORD_WIDTH_OUT, same lane order
//   m_axis_tlast         tlast aligned with its data beat
//   debug_state          current FSM state encoding
// -----------------------------------------------------------------------------
module axis_lrelu_requant #(
    parameter int CH             = 4,
    parameter int WORD_WIDTH_IN  = 32,
    parameter int WORD_WIDTH_OUT = 8,
    parameter int MUL_W          = 16,
    parameter int SH_W           = 5,
    parameter int ALPHA_SHIFT    = 3
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [CH*WORD_WIDTH_IN-1:0]  s_axis_tdata,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [CH*WORD_WIDTH_OUT-1:0] m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic [1:0]                   debug_state
);

    // Product width, and one extra bit so adding the rounding term never wraps.
    localparam int PW = WORD_WIDTH_IN + MUL_W;
    localparam int RW = PW + 1;

    if (WORD_WIDTH_IN < MUL_W + SH_W + 1) begin : g_cfg_width_check
        $error("WORD_WIDTH_IN too narrow to carry a lane config word");
    end

    typedef enum logic [1:0] {
        CFG_S   = 2'd0,
        PASS_S  = 2'd1,
        DRAIN_S = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_v1, r_v2, r_v3;
    logic r_l1, r_l2, r_l3;
    logic [CH*WORD_WIDTH_OUT-1:0] r_data3;
    logic [CH*WORD_WIDTH_OUT-1:0] w_sat_all;

    logic w_en;
    logic w_drained;
    logic w_ready;
    logic w_cfg_load;
    logic w_accept;

    // One global enable: the whole pipeline moves only when the output slot
    // is empty or being consumed this cycle.
    assign w_en = !r_v3 || m_axis_tready;

    // The pipeline is empty as of next cycle: nothing in S1/S2 and the S3 beat
    // (if any) is leaving now. This lets a config beat be taken the cycle after
    // the last output handshake.
    assign w_drained = !r_v1 && !r_v2 && (!r_v3 || m_axis_tready);

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_v3;
    assign m_axis_tdata  = r_data3;
    assign m_axis_tlast  = r_l3;
    assign debug_state   = r_state;

    // Next-state and handshake decode. Config beats are only latched, never
    // sent down the pipeline. The unused encoding falls into the PASS_S branch.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_cfg_load   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            CFG_S: begin
                w_ready = 1'b1;
                if (s_axis_tvalid) begin
                    w_cfg_load   = 1'b1;
                    w_state_next = PASS_S;
                end
            end
            DRAIN_S: begin
                if (w_drained) begin
                    w_state_next = CFG_S;
                end
            end
            default: begin
                w_state_next = PASS_S;
                w_ready      = w_en;
                if (s_axis_tvalid && w_en) begin
                    w_accept = 1'b1;
                    if (s_axis_tlast) begin
                        w_state_next = DRAIN_S;
                    end
                end
            end
        endcase
    end

    // State register plus the valid/tlast shift chain and the output data
    // register. tlast is qualified with acceptance so bubbles carry tlast=0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= CFG_S;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_l1    <= 1'b0;
            r_l2    <= 1'b0;
            r_l3    <= 1'b0;
            r_data3 <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_en) begin
                r_v1    <= w_accept;
                r_l1    <= w_accept & s_axis_tlast;
                r_v2    <= r_v1;
                r_l2    <= r_l1;
                r_v3    <= r_v2;
                r_l3    <= r_l2;
                r_data3 <= w_sat_all;
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        logic signed [MUL_W-1:0] r_mul;
        logic [SH_W-1:0]         r_sh;
        logic                    r_act;
        logic signed [PW-1:0]    r_p1;
        logic signed [RW-1:0]    r_r2;

        logic [WORD_WIDTH_IN-1:0]    w_x;
        logic signed [PW-1:0]        w_xe;
        logic signed [PW-1:0]        w_me;
        logic signed [PW-1:0]        w_p;
        logic signed [RW-1:0]        w_pe;
        logic signed [RW-1:0]        w_rnd;
        logic signed [RW-1:0]        w_sum;
        logic signed [RW-1:0]        w_r;
        logic signed [RW-1:0]        w_leak;
        logic [RW-WORD_WIDTH_OUT:0]  w_hi;
        logic                        w_fits;
        logic [WORD_WIDTH_OUT-1:0]   w_sat;

        assign w_x  = s_axis_tdata[gi*WORD_WIDTH_IN +: WORD_WIDTH_IN];
        assign w_xe = {{MUL_W{w_x[WORD_WIDTH_IN-1]}}, w_x};
        assign w_me = {{WORD_WIDTH_IN{r_mul[MUL_W-1]}}, r_mul};
        assign w_p  = w_xe * w_me;

        assign w_pe = {r_p1[PW-1], r_p1};
`ifdef LRELU_ROUND_EN
        assign w_rnd = (r_sh != '0) ? (RW'(1) << (r_sh - 1'b1)) : '0;
`else
        assign w_rnd = '0;
`endif
        assign w_sum = w_pe + w_rnd;
        assign w_r   = w_sum >>> r_sh;

        assign w_leak = (r_act && r_r2[RW-1]) ? (r_r2 >>> ALPHA_SHIFT) : r_r2;

        // The value fits the output range when every bit from the output sign
        // position upward is a copy of the sign.
        assign w_hi   = w_leak[RW-1:WORD_WIDTH_OUT-1];
        assign w_fits = (&w_hi) || !(|w_hi);
        assign w_sat  = w_fits ? w_leak[WORD_WIDTH_OUT-1:0]
                      : (w_leak[RW-1] ? {1'b1, {(WORD_WIDTH_OUT-1){1'b0}}}
                                      : {1'b0, {(WORD_WIDTH_OUT-1){1'b1}}});

        assign w_sat_all[gi*WORD_WIDTH_OUT +: WORD_WIDTH_OUT] = w_sat;

        // Lane config is loaded only from a config beat; the S1/S2 data
        // registers follow the global enable.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                r_mul <= '0;
                r_sh  <= '0;
                r_act <= 1'b0;
                r_p1  <= '0;
                r_r2  <= '0;
            end else begin
                if (w_cfg_load) begin
                    r_mul <= w_x[MUL_W-1:0];
                    r_sh  <= w_x[MUL_W +: SH_W];
                    r_act <= w_x[MUL_W+SH_W];
                end
                if (w_en) begin
                    r_p1 <= w_p;
                    r_r2 <= w_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_lrelu_requant.sv
// -----------------------------------------------------------------------------
// tb_axis_lrelu_requant
//
// Directed bench for axis_lrelu_requant. A driver pushes the expected output of
// every accepted data beat into a scoreboard; a monitor pops and compares on
// every output handshake. Expected values come from an integer reference model
// built on floor division.
// -----------------------------------------------------------------------------
module tb_axis_lrelu_requant;

    localparam int CH    = 4;
    localparam int WIN   = 32;
    localparam int WOUT  = 8;
    localparam int MUL_W = 16;
    localparam int SH_W  = 5;
    localparam int ALPHA = 3;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic [CH*WIN-1:0]    s_tdata = '0;
    logic                 s_tlast = 1'b0;
    logic                 m_tvalid;
    logic                 m_tready = 1'b1;
    logic [CH*WOUT-1:0]   m_tdata;
    logic                 m_tlast;
    logic [1:0]           dbg;

    axis_lrelu_requant #(
        .CH(CH), .WORD_WIDTH_IN(WIN), .WORD_WIDTH_OUT(WOUT),
        .MUL_W(MUL_W), .SH_W(SH_W), .ALPHA_SHIFT(ALPHA)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast),
        .debug_state(dbg)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [CH*WOUT-1:0] data;
        logic               last;
    } exp_t;

    exp_t sbQ[$];

    int checks = 0;
    int failures = 0;
    int hsCyc = 0;

    int cfgMul[CH];
    int cfgSh[CH];
    int cfgAct[CH];
    int pendMul[CH];
    int pendSh[CH];
    int pendAct[CH];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint floorDiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [WOUT-1:0] modelLane(input longint x, input int lane);
        longint p;
        longint r;
        longint maxV;
        logic [63:0] rb;
        p = x * longint'(cfgMul[lane]);
`ifdef LRELU_ROUND_EN
        if (cfgSh[lane] > 0) p = p + (longint'(1) << (cfgSh[lane] - 1));
`endif
        r = floorDiv(p, longint'(1) << cfgSh[lane]);
        if (cfgAct[lane] != 0 && r < 0) r = floorDiv(r, longint'(1) << ALPHA);
        maxV = (longint'(1) << (WOUT - 1)) - 1;
        if (r > maxV) r = maxV;
        if (r < -maxV - 1) r = -maxV - 1;
        rb = r;
        return rb[WOUT-1:0];
    endfunction

    function automatic logic [CH*WIN-1:0] packData(input int a0, input int a1, input int a2, input int a3);
        logic [CH*WIN-1:0] d;
        int v[4];
        logic [WIN-1:0] t;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        d = '0;
        for (int i = 0; i < CH; i++) begin
            t = v[i];
            d[i*WIN +: WIN] = t;
        end
        return d;
    endfunction

    // Config word from the pending lane settings; junk in the ignored upper bits.
    function automatic logic [CH*WIN-1:0] cfgWord();
        logic [CH*WIN-1:0] d;
        logic [WIN-1:0] w;
        logic [31:0] m;
        logic [31:0] s;
        d = '0;
        for (int i = 0; i < CH; i++) begin
            m = pendMul[i];
            s = pendSh[i];
            w = '0;
            w[MUL_W-1:0] = m[MUL_W-1:0];
            w[MUL_W +: SH_W] = s[SH_W-1:0];
            w[MUL_W+SH_W] = (pendAct[i] != 0);
            w[WIN-1:MUL_W+SH_W+1] = 10'h2A5;
            d[i*WIN +: WIN] = w;
        end
        return d;
    endfunction

    task automatic setPend(input int lane, input int mul, input int sh, input int act);
        pendMul[lane] = mul;
        pendSh[lane]  = sh;
        pendAct[lane] = act;
    endtask

    task automatic setPendAll(input int mul, input int sh, input int act);
        for (int i = 0; i < CH; i++) setPend(i, mul, sh, act);
    endtask

    // Drive one beat and hold it until accepted (bounded). tvalid stays high
    // on return so consecutive calls stream back-to-back.
    task automatic applyStimulus(input logic [CH*WIN-1:0] data, input logic last, input bit isCfg);
        bit done;
        exp_t e;
        logic [WIN-1:0] lw;
        done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge aclk);
            if (s_tready === 1'b1) done = 1'b1;
        end
        checkOutput("handshake_wait", 64'(done), 64'(1));
        if (done) begin
            hsCyc = cyc;
            if (isCfg) begin
                for (int i = 0; i < CH; i++) begin
                    cfgMul[i] = pendMul[i];
                    cfgSh[i]  = pendSh[i];
                    cfgAct[i] = pendAct[i];
                end
            end else begin
                for (int i = 0; i < CH; i++) begin
                    lw = data[i*WIN +: WIN];
                    e.data[i*WOUT +: WOUT] = modelLane(longint'($signed(lw)), i);
                end
                e.last = last;
                sbQ.push_back(e);
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge aclk);
            if (sbQ.size() == 0 && dbg == 2'd0 && m_tvalid === 1'b0) done = 1'b1;
        end
        checkOutput(tag, 64'(done), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitor: compare every output handshake in order.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checkOutput("sb_has_entry", 64'(sbQ.size() != 0), 64'(1));
            if (sbQ.size() != 0) begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sb_data", 64'(m_tdata), 64'(e.data));
                checkOutput("sb_last", 64'(m_tlast), 64'(e.last));
            end
        end
    end

    initial begin
        int tLast;
        for (int i = 0; i < CH; i++) begin
            cfgMul[i] = 0; cfgSh[i] = 0; cfgAct[i] = 0;
        end
        setPendAll(0, 0, 0);

        // Reset state
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        checkOutput("rst_m_tlast", 64'(m_tlast), 64'(0));
        checkOutput("rst_m_tdata", 64'(m_tdata), 64'(0));
        checkOutput("rst_state", 64'(dbg), 64'(0));
        checkOutput("rst_s_tready", 64'(s_tready), 64'(1));
        @(posedge aclk);
        #1;

        // Identity with saturation and 3-cycle latency; tlast on config ignored
        $display("[TB] identity");
        setPendAll(1, 0, 0);
        applyStimulus(cfgWord(), 1'b1, 1'b1);
        applyStimulus(packData(5, -7, 200, -300), 1'b1, 1'b0);
        idle();
        @(negedge aclk);
        checkOutput("t1_lat_c1", 64'(m_tvalid), 64'(0));
        @(posedge aclk); #1;
        @(negedge aclk);
        checkOutput("t1_lat_c2", 64'(m_tvalid), 64'(0));
        @(posedge aclk); #1;
        @(negedge aclk);
        checkOutput("t1_lat_c3", 64'(m_tvalid), 64'(1));
        checkOutput("t1_data", 64'(m_tdata), 64'(32'h807FF905));
        checkOutput("t1_last", 64'(m_tlast), 64'(1));
        @(posedge aclk); #1;
        waitIdle("t1_drain");

        // Leaky requant with rounding option
        $display("[TB] leaky requant");
        setPendAll(3, 2, 1);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        applyStimulus(packData(10, -10, 0, 1000), 1'b1, 1'b0);
        idle();
        waitIdle("t2_drain");

        // Backpressure mid-stream
        $display("[TB] backpressure");
        setPendAll(1, 0, 0);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        for (int b = 0; b < 4; b++)
            applyStimulus(packData(b*37-100, b*37-50, b*37, b*37+50), 1'b0, 1'b0);
        idle();
        m_tready = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            checkOutput("t3_stall_s_tready", 64'(s_tready), 64'(0));
            checkOutput("t3_stall_m_tvalid", 64'(m_tvalid), 64'(1));
            @(posedge aclk); #1;
        end
        m_tready = 1'b1;
        for (int b = 4; b < 8; b++)
            applyStimulus(packData(b*37-100, b*37-50, b*37, b*37+50), (b == 7), 1'b0);
        idle();
        waitIdle("t3_drain");

        // Reconfig waits for the pipeline to drain
        $display("[TB] reconfig drain");
        setPendAll(1, 0, 0);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        applyStimulus(packData(11, -22, 33, -44), 1'b0, 1'b0);
        applyStimulus(packData(60, 70, -80, -90), 1'b0, 1'b0);
        applyStimulus(packData(1, 2, 3, 4), 1'b1, 1'b0);
        tLast = hsCyc;
        setPendAll(-1, 1, 0);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        checkOutput("t4_cfg_delay", 64'(hsCyc - tLast), 64'(4));
        applyStimulus(packData(9, -9, 100, -255), 1'b0, 1'b0);
        applyStimulus(packData(300, -300, 1, -1), 1'b1, 1'b0);
        idle();
        waitIdle("t4_drain");

        // Reset with beats in flight
        $display("[TB] reset mid-stream");
        setPendAll(2, 0, 0);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        applyStimulus(packData(1, 2, 3, 4), 1'b0, 1'b0);
        applyStimulus(packData(5, 6, 7, 8), 1'b0, 1'b0);
        idle();
        aresetn = 1'b0;
        sbQ.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("t5_m_tvalid", 64'(m_tvalid), 64'(0));
        checkOutput("t5_state", 64'(dbg), 64'(0));
        checkOutput("t5_s_tready", 64'(s_tready), 64'(1));
        repeat (4) begin
            @(negedge aclk);
            checkOutput("t5_no_ghost", 64'(m_tvalid), 64'(0));
        end
        @(posedge aclk); #1;

        // Next beat is config; per-lane activation independence
        $display("[TB] per-lane independence");
        setPend(0, 1, 0, 1);
        setPend(1, 1, 0, 0);
        setPend(2, -2, 1, 1);
        setPend(3, -2, 1, 0);
        applyStimulus(cfgWord(), 1'b0, 1'b1);
        applyStimulus(packData(-16, -16, -16, 50), 1'b1, 1'b0);
        idle();
        @(negedge aclk);
        @(posedge aclk); #1;
        @(negedge aclk);
        @(posedge aclk); #1;
        @(negedge aclk);
        checkOutput("t6_lane01", 64'(m_tdata[15:0]), 64'(16'hF0FE));
        @(posedge aclk); #1;
        waitIdle("t6_drain");

        checkOutput("sb_empty", 64'(sbQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
